// File: rtl/ahb_pkg.sv
// Shared state encoding, width defaults and bus field encodings for the
// AHB burst master.
package ahb_pkg;
    localparam int ADDR_W_DEF = 31;
    localparam int DATA_W_DEF = 32;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_ACTIVE = 1'b1;
    localparam logic HBURST_END    = 1'b0;
    localparam logic HBURST_INCR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LAST
    } state_t;
endpackage

// File: rtl/wdata_fifo.sv
// Synchronous write-data FIFO with occupancy count; pushes when full and
// pops when empty are ignored.
module wdata_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign w_push  = i_push && (r_count < CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= ptr_inc(r_wp);
            if (w_pop)  r_rp <= ptr_inc(r_rp);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/ahb_master.sv
// AHB-style burst master: one command becomes 1..4 incrementing beats on a
// pipelined address/data bus; write data is staged in a small FIFO.
module ahb_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              done,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic              HTRANS,
    output logic              HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);
    localparam int CW = $clog2(WFIFO_DEPTH + 1);

    state_t            r_state, w_next;
    logic [1:0]        r_len, r_beat;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite, r_htrans, r_hburst;
    logic [DATA_W-1:0] r_hwdata, r_rsp_rdata;
    logic              r_rd_pend, r_rd_last;
    logic              r_rsp_valid, r_rsp_last, r_done;
    logic [CW-1:0]     w_count;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_cmd_ready, w_accept, w_adv, w_more, w_pop;

    assign w_accept = cmd_valid && w_cmd_ready;
    assign w_adv    = (r_state == ST_ADDR) && HREADY;
    assign w_more   = r_beat != r_len;
    assign w_pop    = w_adv && r_hwrite;

    wdata_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     (DATA_W),
        .CW    (CW)
    ) u_wfifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (wd_valid),
        .i_data  (wd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // A write is only accepted once every beat of it is already buffered.
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = !cmd_write || (32'(w_count) >= 32'(cmd_len) + 32'd1);
                if (cmd_valid && w_cmd_ready) w_next = ST_ADDR;
            end
            ST_ADDR: if (HREADY && !w_more) w_next = ST_LAST;
            ST_LAST: if (HREADY) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_len       <= '0;
            r_beat      <= '0;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_hburst    <= HBURST_END;
            r_hwdata    <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_rdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == ST_LAST) && HREADY;
            if (w_accept) begin
                r_len    <= cmd_len;
                r_beat   <= '0;
                r_haddr  <= cmd_addr;
                r_hwrite <= cmd_write;
                r_htrans <= HTRANS_ACTIVE;
                r_hburst <= (cmd_len != 2'd0) ? HBURST_INCR : HBURST_END;
            end else if (w_adv) begin
                if (w_more) begin
                    r_beat   <= r_beat + 2'd1;
                    r_haddr  <= r_haddr + ADDR_W'(1);
                    r_hburst <= (r_beat + 2'd1 != r_len) ? HBURST_INCR : HBURST_END;
                end else begin
                    r_htrans <= HTRANS_IDLE;
                    r_hburst <= HBURST_END;
                end
            end
            if (w_pop) r_hwdata <= w_fifo_data;
            // A read's data phase is the cycle after its address is taken;
            // it stretches with HREADY and may overlap the next address.
            if (HREADY) begin
                r_rd_pend <= w_adv && !r_hwrite;
                r_rd_last <= !w_more;
            end
            r_rsp_valid <= HREADY && r_rd_pend;
            r_rsp_last  <= HREADY && r_rd_pend && r_rd_last;
            if (HREADY && r_rd_pend) r_rsp_rdata <= HRDATA;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign wd_ready  = 32'(w_count) < 32'(WFIFO_DEPTH);
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HTRANS    = r_htrans;
    assign HBURST    = r_hburst;
    assign HWDATA    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign rsp_rdata = r_rsp_rdata;
    assign done      = r_done;
endmodule

// File: tb/tb_ahb_master.sv
// Scoreboard bench for ahb_master: stimulus queues expected beats, write
// data and read responses; a negedge monitor pops and compares them.
module tb_ahb_master;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [30:0] cmd_addr = '0;
    logic [1:0]  cmd_len = '0;
    logic        wd_valid = 1'b0;
    logic [31:0] wd_data = '0;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        cmd_ready, wd_ready, rsp_valid, rsp_last, done;
    logic [31:0] rsp_rdata, HWDATA;
    logic [30:0] HADDR;
    logic        HWRITE, HTRANS, HBURST;

    ahb_master #(.ADDR_W(31), .DATA_W(32), .WFIFO_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .done(done),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { logic [30:0] a; logic b; logic w; } beat_t;
    typedef struct { logic [31:0] d; logic l; } rsp_t;

    beat_t       q_beat[$];
    logic [31:0] q_wd[$];
    rsp_t        q_rsp[$];
    logic [31:0] mq[$];           // reference model of the write FIFO

    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0, htr_cyc = 0, done_cyc = 0;
    int done_cnt = 0, exp_done = 0, rsp_cnt = 0, hold_cnt = 0;
    int hz_from = 0, hz_to = 0;
    bit hr_rand = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    function automatic logic [31:0] slv(input logic [30:0] a);
        return (a == 31'h5) ? 32'hDEADBEEF : (({1'b0, a} * 32'h9E3779B1) ^ 32'h0F0F1234);
    endfunction

    // Slave: wait-state generator and read data for the address in data phase.
    logic [30:0] s_daddr = '0;
    always begin
        @(negedge HCLK);
        if (HTRANS && HREADY) s_daddr = HADDR;
        @(posedge HCLK);
        #1;
        if (cyc >= hz_from && cyc < hz_to) HREADY = 1'b0;
        else if (hr_rand)                  HREADY = ($urandom_range(0, 3) != 0);
        else                               HREADY = 1'b1;
        HRDATA = slv(s_daddr);
    end

    // Monitor / scoreboard.
    bit          dp_pend = 0, dp_wr = 0, p_hold = 0, p_tr = 0;
    logic [30:0] p_addr = '0;
    logic        p_b = 0, p_w = 0;
    always @(negedge HCLK) begin : mon
        beat_t b;
        rsp_t  r;
        if (HRESET) begin
            q_beat.delete(); q_wd.delete(); q_rsp.delete();
            dp_pend = 0;
        end else begin
            if (dp_pend && HREADY) begin
                if (dp_wr) begin
                    if (q_wd.size() == 0) chk("hwdata_unexpected", 1, 0);
                    else chk("hwdata", HWDATA, q_wd.pop_front());
                end
                dp_pend = 0;
            end
            if (p_hold) begin
                hold_cnt++;
                chk("bus_hold", {HADDR, HTRANS, HBURST, HWRITE}, {p_addr, 1'b1, p_b, p_w});
            end
            if (HTRANS && !p_tr) htr_cyc = cyc;
            if (HTRANS && HREADY) begin
                if (q_beat.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    b = q_beat.pop_front();
                    chk("haddr_hburst_hwrite", {HADDR, HBURST, HWRITE}, {b.a, b.b, b.w});
                end
                dp_pend = 1;
                dp_wr   = HWRITE;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (q_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    r = q_rsp.pop_front();
                    chk("rsp_rdata_last", {rsp_rdata, rsp_last}, {r.d, r.l});
                end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
        p_hold = !HRESET && HTRANS && !HREADY;
        p_tr   = HTRANS;
        p_addr = HADDR; p_b = HBURST; p_w = HWRITE;
    end

    task automatic push(input logic [31:0] d);
        bit room;
        @(posedge HCLK); #1;
        wd_valid = 1'b1; wd_data = d;
        @(negedge HCLK);
        room = mq.size() < 4;
        chk("wd_ready", wd_ready, room);
        if (room) mq.push_back(d);
        @(posedge HCLK); #1;
        wd_valid = 1'b0;
    endtask

    task automatic expect_cmd(input logic wr, input logic [30:0] a, input logic [1:0] l);
        beat_t b;
        rsp_t  r;
        acc_cyc = cyc;
        exp_done++;
        for (int i = 0; i <= int'(l); i++) begin
            b.a = a + 31'(i); b.b = (i < int'(l)); b.w = wr;
            q_beat.push_back(b);
            if (wr) q_wd.push_back(mq.pop_front());
            else begin
                r.d = slv(b.a); r.l = (i == int'(l));
                q_rsp.push_back(r);
            end
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [30:0] a, input logic [1:0] l, output bit ok);
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        @(negedge HCLK);
        chk("cmd_ready", cmd_ready, (!wr || mq.size() >= int'(l) + 1));
        ok = cmd_ready;
        if (ok) expect_cmd(wr, a, l);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit lat, input int beats);
        int k = 0;
        while (done_cnt < exp_done && k < 400) begin @(negedge HCLK); k++; end
        chk("done_count", done_cnt, exp_done);
        @(negedge HCLK);
        chk("scoreboard_drained", q_beat.size() + q_wd.size() + q_rsp.size(), 0);
        if (lat) begin
            chk("latency_first_htrans", htr_cyc - acc_cyc, 1);
            chk("latency_done", done_cyc - acc_cyc, beats + 2);
        end
    endtask

    task automatic issue(input logic wr, input logic [30:0] a, input logic [1:0] l, input bit lat);
        bit ok;
        start_cmd(wr, a, l, ok);
        if (ok) wait_done(lat, int'(l) + 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bus"}, {HTRANS, HBURST, HWRITE, HADDR}, 0);
        chk({tag, "_hwdata"}, HWDATA, 0);
        chk({tag, "_rsp_done"}, {rsp_valid, rsp_last, done, rsp_rdata}, 0);
        chk({tag, "_wd_ready"}, wd_ready, 1);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit          ok;
        int          k, r0, h0, d0;
        logic        wr;
        logic [1:0]  l;
        logic [30:0] a;

        repeat (3) @(posedge HCLK);
        #1;
        chk_reset("reset");
        chk("reset_cmd_ready_read", cmd_ready, 1);
        HRESET = 1'b0;

        // 4-beat write, no wait states
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        issue(1'b1, 31'h10, 2'd3, 1'b1);
        // single read
        issue(1'b0, 31'h5, 2'd0, 1'b1);
        // address wrap
        issue(1'b0, 31'h7FFFFFFF, 2'd1, 1'b1);

        // write held off until the FIFO holds the whole burst
        push(32'hB0); push(32'hB1);
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 31'h20; cmd_len = 2'd3;
        @(negedge HCLK); chk("ready_with_2_of_4", cmd_ready, 0);
        push(32'hB2);
        @(negedge HCLK); chk("ready_with_3_of_4", cmd_ready, 0);
        push(32'hB3);
        @(negedge HCLK); chk("ready_with_4_of_4", cmd_ready, 1);
        chk("wd_ready_full", wd_ready, 0);
        expect_cmd(1'b1, 31'h20, 2'd3);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        wait_done(1'b1, 4);

        // three wait states in the middle of a read burst
        r0 = rsp_cnt; h0 = hold_cnt;
        hz_from = cyc + 4; hz_to = cyc + 7;
        issue(1'b0, 31'h40, 2'd3, 1'b0);
        chk("stall_rsp_count", rsp_cnt - r0, 4);
        chk("stall_hold_cycles", hold_cnt - h0, 3);

        // reset while the address phase of beat 2 is on the bus
        for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
        start_cmd(1'b1, 31'h100, 2'd3, ok);
        k = 0;
        while (!(HTRANS && HADDR == 31'h102) && k < 20) begin @(negedge HCLK); k++; end
        chk("abort_reached_beat2", HADDR, 31'h102);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        chk_reset("abort");
        cmd_write = 1'b1; cmd_len = 2'd0;
        #1 chk("abort_fifo_empty", cmd_ready, 0);
        @(negedge HCLK);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        mq.delete();
        exp_done = done_cnt;
        d0 = done_cnt; r0 = rsp_cnt;
        repeat (4) @(negedge HCLK);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_rsp", rsp_cnt, r0);
        push(32'hD0);
        issue(1'b1, 31'h200, 2'd0, 1'b1);

        // randomized bursts with random wait states
        hr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            l  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 31'h7FFFFFFF - 31'($urandom_range(0, 2))
                                             : 31'($urandom);
            if (wr) while (mq.size() < int'(l) + 1) push($urandom);
            repeat ($urandom_range(0, 2)) push($urandom);
            issue(wr, a, l, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
